// File: rtl/vga_scan_reader.sv
`default_nettype none
// ============================================================================
// Module   : vga_scan_reader
// Purpose  : VGA timing generator and frame-buffer reader. It scans a 320x240
//            buffer with 2x pixel and line replication and registers the RGB
//            output so that it stays aligned with the sync signals.
// Revision : 1.0
// ============================================================================
module vga_scan_reader #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] pixel_out,
  output logic [7:0]  row_read,
  output logic [8:0]  col_read,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        blank,
  output logic        frame_start
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [DIV_W-1:0] C_DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       C_H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]       C_V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]       C_H_ACTIVE  = 10'(H_ACTIVE);
  localparam logic [9:0]       C_V_ACTIVE  = 10'(V_ACTIVE);
  localparam logic [9:0]       C_HS_START  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]       C_HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]       C_VS_START  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]       C_VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] r_div;
  logic [9:0]       r_h;
  logic [9:0]       r_v;
  logic [11:0]      r_rgb;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_blank;
  logic             r_frame_start;

  logic w_tick;
  logic w_h_last;
  logic w_v_last;
  logic w_active;

  assign w_tick   = (r_div == C_DIV_LAST);
  assign w_h_last = (r_h == C_H_LAST);
  assign w_v_last = (r_v == C_V_LAST);
  assign w_active = (r_h < C_H_ACTIVE) && (r_v < C_V_ACTIVE);

  // Halving the counters gives the 2x replication of the buffer image.
  assign col_read = w_active ? r_h[9:1] : 9'd0;
  assign row_read = w_active ? r_v[8:1] : 8'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
      r_h   <= '0;
      r_v   <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick) begin
        if (w_h_last) begin
          r_h <= '0;
          r_v <= w_v_last ? 10'd0 : r_v + 10'd1;
        end else begin
          r_h <= r_h + 10'd1;
        end
      end
    end
  end

  // Output stage samples the counters and the returned pixel together, so
  // RGB, blank and both syncs share one pixel period of latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rgb         <= 12'h000;
      r_blank       <= 1'b1;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_tick && w_h_last && w_v_last;
      if (w_tick) begin
        r_rgb   <= w_active ? pixel_out : 12'h000;
        r_blank <= !w_active;
        r_hsync <= !((r_h >= C_HS_START) && (r_h <= C_HS_END));
        r_vsync <= !((r_v >= C_VS_START) && (r_v <= C_VS_END));
      end
    end
  end

  assign vga_r       = r_rgb[11:8];
  assign vga_g       = r_rgb[7:4];
  assign vga_b       = r_rgb[3:0];
  assign blank       = r_blank;
  assign vga_hsync   = r_hsync;
  assign vga_vsync   = r_vsync;
  assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_scan_reader
// Purpose  : Randomized bench for vga_scan_reader using reduced timing and a
//            position-based reference model of the scan.
// Revision : 1.0
// ============================================================================
module tb_vga_scan_reader;

  localparam int CD = 2;
  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] pixel_out;
  logic [7:0]  row_read;
  logic [8:0]  col_read;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hsync, vga_vsync, blank, frame_start;

  logic [11:0] key   = 12'h000;
  logic        white = 1'b0;
  int          edges;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  vga_scan_reader #(
    .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst(rst), .pixel_out(pixel_out),
    .row_read(row_read), .col_read(col_read),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .blank(blank), .frame_start(frame_start)
  );

  // Frame-buffer model: combinational lookup on the read address.
  always_comb pixel_out = white ? 12'hFFF : ({row_read[3:0], col_read[7:0]} ^ key);

  always @(posedge clk or posedge rst)
    if (rst) edges <= 0;
    else     edges <= edges + 1;

  function automatic logic [11:0] buf_pix(input int row, input int col);
    logic [7:0] r8;
    logic [8:0] c9;
    r8 = 8'(row);
    c9 = 9'(col);
    return white ? 12'hFFF : ({r8[3:0], c9[7:0]} ^ key);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edges, obs, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_rgb",   {vga_r, vga_g, vga_b}, 12'h000);
    chk("rst_blank", blank, 1'b1);
    chk("rst_hsync", vga_hsync, 1'b1);
    chk("rst_vsync", vga_vsync, 1'b1);
    chk("rst_fs",    frame_start, 1'b0);
    chk("rst_row",   row_read, 8'd0);
    chk("rst_col",   col_read, 9'd0);
  endtask

  // Expected state after 'edges' rising edges since reset release: k ticks
  // have happened, the output shows scan position k-1, counters sit at k.
  task automatic chk_cycle();
    int k, p, h, v, q, hq, vq;
    logic act, act_q;
    k = edges / CD;
    q  = k % FT;
    hq = q % HT;
    vq = q / HT;
    act_q = (hq < HA) && (vq < VA);
    chk("col_read", col_read, act_q ? 32'(hq / 2) : 32'd0);
    chk("row_read", row_read, act_q ? 32'(vq / 2) : 32'd0);
    chk("frame_start", frame_start,
        ((edges % CD) == 0) && (k > 0) && ((k % FT) == 0));
    if (k == 0) begin
      chk("rgb0", {vga_r, vga_g, vga_b}, 12'h000);
      chk("blank0", blank, 1'b1);
      chk("hsync0", vga_hsync, 1'b1);
      chk("vsync0", vga_vsync, 1'b1);
    end else begin
      p = (k - 1) % FT;
      h = p % HT;
      v = p / HT;
      act = (h < HA) && (v < VA);
      chk("rgb", {vga_r, vga_g, vga_b}, act ? buf_pix(v / 2, h / 2) : 12'h000);
      chk("blank", blank, !act);
      chk("hsync", vga_hsync, !((h >= HA + HF) && (h <= HA + HF + HS - 1)));
      chk("vsync", vga_vsync, !((v >= VA + VF) && (v <= VA + VF + VS - 1)));
    end
  endtask

  initial begin
    int len;
    #1 rst = 1'b1;
    #2 chk_reset_vals();
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    for (int seg = 0; seg < 8; seg++) begin
      if (seg == 0)      len = 3 * FT * CD + 40;
      else if (seg == 1) len = 2 * FT * CD + 7;
      else               len = $urandom_range(150, 1400);
      repeat (len) begin
        @(negedge clk);
        chk_cycle();
      end
      // Asynchronous reset mid-frame, between clock edges.
      @(posedge clk);
      #2 rst = 1'b1;
      #1 chk_reset_vals();
      key   = 12'($urandom);
      white = (seg == 2) || ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst = 1'b0;
    end
    repeat (FT * CD + 5) begin
      @(negedge clk);
      chk_cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
